rst_clear_sequencer: RTL and testbench
======================================

// Module: rst_clear_sequencer
// PURPOSE
//  Generates the per-domain clear signals consumed by the sync- and async-clear flops.
//  - Synchronises deassertion of the board reset.
//  - Holds all domains in reset for a fixed time, then releases them in staggered order.
//  - After that, serves software clear requests over a four-phase req/ack handshake.
//  - Sits between the top-level reset pin and every clocked block in the design.
// PARAMETERS
//  SYNC_STAGES  2   reset-deassert synchroniser depth (>=2)
//  HOLD_CYCLES  16  cycles all domains stay in reset after synchronised deassert (>=1)
//  NUM_DOMAINS  4   number of reset outputs (>=1)
//  STAGE_GAP    4   cycles between successive domain releases (>=1)
//  CLR_WIDTH    3   cycles rst_out is held high for a software clear (>=1)
// PORTS
//  clk      in   1            single clock, rising edge
//  rst      in   1            asynchronous reset, active-high
//  clr_req  in   1            software clear request; hold high until clr_ack=1
//  clr_ack  out  1            clear-done acknowledge; high until clr_req low
//  rst_out  out  NUM_DOMAINS  per-domain reset, active-high, registered
//  ready    out  1            1 = all domains out of reset, idle in RUN
// BEHAVIOUR
//  - Reset values: rst=1 forces the following asynchronously, with no clock edge needed:
//    rst_out=all 1, ready=0, clr_ack=0, state=RESET, counters=0, synchroniser=all 1.
//  - rst takes effect in any state, mid-operation; the full power-on sequence then restarts.
//  - Synchroniser: after rst falls, zeros shift in; rst_sync=0 after SYNC_STAGES rising edges.
//  - FSM states: RESET, HOLD, RELEASE, RUN, CLEAR, ACK.
//  - RESET -> HOLD: first edge sampling rst_sync=0.
//    HOLD is therefore entered on the (SYNC_STAGES+1)th edge after rst falls.
//  - Let T0 be the first cycle in HOLD.
//  - HOLD lasts exactly HOLD_CYCLES cycles; rst_out stays all 1.
//  - RELEASE starts at T1 = T0+HOLD_CYCLES.
//    rst_out[i] goes 0 from cycle T1+i*STAGE_GAP and stays 0.
//    Lower indices release first.
//  - RUN is entered at T1+(NUM_DOMAINS-1)*STAGE_GAP+1; ready=1 in every RUN cycle.
//  - RUN -> CLEAR: edge sampling clr_req=1.
//    clr_req is ignored in RESET/HOLD/RELEASE and is not remembered.
//    A request still high on entry to RUN is sampled on the first RUN edge.
//  - CLEAR: rst_out=all 1 and ready=0 for exactly CLR_WIDTH cycles; no stagger.
//  - CLEAR -> ACK after CLR_WIDTH cycles.
//    In ACK: rst_out=all 0, clr_ack=1, ready=0.
//  - ACK -> RUN: edge sampling clr_req=0; clr_ack=0 and ready=1 from the next cycle.
//    If clr_req stays high, ACK persists indefinitely; no re-trigger until clr_req drops.
//  - Counters are sized $clog2 of the max count + 1; they saturate and never wrap.
//    With STAGE_GAP=1, domains release on consecutive cycles.
//    With NUM_DOMAINS=1, RUN is entered at T1+1.
//  - All outputs are driven from flops; no combinational path from inputs to outputs.
// TESTING (defaults unless stated)
//  1 Power-on: rst=1 for 20 cycles, then 0.
//    -> rst_out=4'hF throughout; HOLD at 3rd edge (T0).
//    -> rst_out = 4'hE @T0+16, 4'hC @T0+20, 4'h8 @T0+24, 4'h0 @T0+28; ready=1 @T0+29.
//  2 rst pulsed mid-RELEASE while rst_out=4'hC, between clock edges.
//    -> rst_out=4'hF and ready=0 in the same timestep; complete sequence repeats as in test 1.
//  3 In RUN, clr_req=1.
//    -> next cycle rst_out=4'hF for 3 cycles, then 4'h0 with clr_ack=1.
//    -> drop clr_req: clr_ack=0 and ready=1 one cycle later.
//  4 clr_req held 1 from T0.
//    -> no clear during HOLD/RELEASE; ready=1 @T0+29 for one cycle.
//    -> CLEAR starts @T0+30; ACK held until clr_req released.
//  5 rst glitch of 2 time units, no clock edge inside it, while in RUN.
//    -> immediate rst_out=4'hF; full restart; ready=0 until T0+29 of the new sequence.
//  6 Build with NUM_DOMAINS=1, STAGE_GAP=1, HOLD_CYCLES=1, CLR_WIDTH=1.
//    -> rst_out=0 @T0+1, ready @T0+2; a clear gives a 1-cycle rst_out pulse, then ack.

Source files
------------

// File: rtl/rst_clear_sequencer.sv
// Reset/clear sequencer: synchronises board-reset deassertion, holds and releases
// the per-domain resets in staggered order, then serves req/ack software clears.
module rst_clear_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned CLR_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    output logic                   clr_ack,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > CLR_WIDTH) ? HOLD_CYCLES : CLR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_W   = $clog2(STAGE_GAP + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(STAGE_GAP);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_CLEAR,
        ST_ACK
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic                   clr_ack_q, clr_ack_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    // Assert asynchronously, deassert only after SYNC_STAGES clean edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            gap_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            clr_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            clr_ack_q <= clr_ack_d;
        end
    end

    // Outputs are computed from the next state so they change together with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rst_out_d = rst_out_q;

        case (state_q)
            ST_RESET: begin
                rst_out_d = '1;
                if (!rst_sync) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_RELEASE;
                    gap_d     = '0;
                    rst_out_d = rst_out_q << 1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Shifting zeros in from bit 0 releases the lowest held domain each step.
            ST_RELEASE: begin
                if (rst_out_q == '0) begin
                    state_d = ST_RUN;
                end else if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    rst_out_d = rst_out_q << 1;
                end else if (gap_q != GAP_SAT) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    rst_out_d = '1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d   = ST_ACK;
                    rst_out_d = '0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (!clr_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_RESET;
                rst_out_d = '1;
            end
        endcase

        ready_d   = (state_d == ST_RUN);
        clr_ack_d = (state_d == ST_ACK);
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign clr_ack = clr_ack_q;

endmodule

// File: tb/tb_rst_clear_sequencer.sv
// Bench for rst_clear_sequencer: timeline vectors relative to T0 checked via a
// scoreboard queue, plus hand sequences for reset glitches and a minimal build.
module tb_rst_clear_sequencer;

    logic       clk;
    logic       rst;
    logic       clr_req;
    logic       clr_ack;
    logic [3:0] rst_out;
    logic       ready;

    logic       rst6;
    logic       clr6;
    logic       clr_ack6;
    logic [0:0] rst_out6;
    logic       ready6;

    int n_pass;
    int n_total;
    int cyc;

    rst_clear_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .clr_ack (clr_ack),
        .rst_out (rst_out),
        .ready   (ready)
    );

    rst_clear_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .NUM_DOMAINS (1),
        .STAGE_GAP   (1),
        .CLR_WIDTH   (1)
    ) dut6 (
        .clk     (clk),
        .rst     (rst6),
        .clr_req (clr6),
        .clr_ack (clr_ack6),
        .rst_out (rst_out6),
        .ready   (ready6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         off;
        logic       req_after;
        logic [3:0] exp_rst;
        logic       exp_rdy;
        logic       exp_ack;
    } vec_t;

    typedef struct {
        int         off;
        logic [5:0] v;
    } exp_t;

    localparam int NV = 28;
    vec_t vec [NV];
    exp_t sb [$];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rst_out=%h ready=%b ack=%b, want rst_out=%h ready=%b ack=%b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        clr_req = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", {rst_out, ready, clr_ack}, {4'hF, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = -3;
    endtask

    // Cycle offsets are counted from T0; cyc=-3 is the cycle in which rst falls.
    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_t e;
            exp_t got;
            e.off = vec[i].off;
            e.v   = {vec[i].exp_rst, vec[i].exp_rdy, vec[i].exp_ack};
            sb.push_back(e);
            while (cyc < vec[i].off) step();
            got = sb.pop_front();
            check($sformatf("vec%0d_T0%0d", i, got.off), {rst_out, ready, clr_ack}, got.v);
            clr_req = vec[i].req_after;
        end
    endtask

    // Short rst pulse between clock edges; outputs must react with no edge.
    task automatic glitch(input string name);
        #2 rst = 1'b1;
        #1 check(name, {rst_out, ready, clr_ack}, {4'hF, 1'b0, 1'b0});
        #1 rst = 1'b0;
        cyc = -3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst     = 1'b1;
        rst6    = 1'b1;
        clr_req = 1'b0;
        clr6    = 1'b0;

        // Power-on, then a software clear in RUN.
        vec[0]  = '{-2, 1'b0, 4'hF, 1'b0, 1'b0};
        vec[1]  = '{-1, 1'b0, 4'hF, 1'b0, 1'b0};
        vec[2]  = '{ 0, 1'b0, 4'hF, 1'b0, 1'b0};
        vec[3]  = '{15, 1'b0, 4'hF, 1'b0, 1'b0};
        vec[4]  = '{16, 1'b0, 4'hE, 1'b0, 1'b0};
        vec[5]  = '{19, 1'b0, 4'hE, 1'b0, 1'b0};
        vec[6]  = '{20, 1'b0, 4'hC, 1'b0, 1'b0};
        vec[7]  = '{23, 1'b0, 4'hC, 1'b0, 1'b0};
        vec[8]  = '{24, 1'b0, 4'h8, 1'b0, 1'b0};
        vec[9]  = '{27, 1'b0, 4'h8, 1'b0, 1'b0};
        vec[10] = '{28, 1'b0, 4'h0, 1'b0, 1'b0};
        vec[11] = '{29, 1'b0, 4'h0, 1'b1, 1'b0};
        vec[12] = '{31, 1'b1, 4'h0, 1'b1, 1'b0};
        vec[13] = '{32, 1'b1, 4'hF, 1'b0, 1'b0};
        vec[14] = '{34, 1'b1, 4'hF, 1'b0, 1'b0};
        vec[15] = '{35, 1'b1, 4'h0, 1'b0, 1'b1};
        vec[16] = '{38, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[17] = '{39, 1'b0, 4'h0, 1'b1, 1'b0};
        vec[18] = '{41, 1'b0, 4'h0, 1'b1, 1'b0};
        // clr_req held high from T0.
        vec[19] = '{ 0, 1'b1, 4'hF, 1'b0, 1'b0};
        vec[20] = '{16, 1'b1, 4'hE, 1'b0, 1'b0};
        vec[21] = '{28, 1'b1, 4'h0, 1'b0, 1'b0};
        vec[22] = '{29, 1'b1, 4'h0, 1'b1, 1'b0};
        vec[23] = '{30, 1'b1, 4'hF, 1'b0, 1'b0};
        vec[24] = '{32, 1'b1, 4'hF, 1'b0, 1'b0};
        vec[25] = '{33, 1'b1, 4'h0, 1'b0, 1'b1};
        vec[26] = '{40, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[27] = '{41, 1'b0, 4'h0, 1'b1, 1'b0};

        // rst pulse mid-RELEASE while rst_out=C, then full restart.
        do_reset();
        run_table(0, 6);
        glitch("glitch_release");
        run_table(0, 18);

        // rst glitch in RUN, then full restart.
        glitch("glitch_run");
        run_table(0, 11);

        do_reset();
        run_table(19, 27);

        // Minimal build: one domain, unit hold/gap/clear.
        check("t6_reset", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst6 = 1'b0;
        repeat (3) step();
        check("t6_T0", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b1, 1'b0, 1'b0});
        step();
        check("t6_T0+1", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b0, 1'b0, 1'b0});
        step();
        check("t6_T0+2", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b0, 1'b1, 1'b0});
        clr6 = 1'b1;
        step();
        check("t6_clear", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b1, 1'b0, 1'b0});
        step();
        check("t6_ack", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b0, 1'b0, 1'b1});
        step();
        check("t6_ack_held", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b0, 1'b0, 1'b1});
        clr6 = 1'b0;
        step();
        check("t6_run", {3'b000, rst_out6, ready6, clr_ack6}, {3'b000, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
